// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose
//   Branch resolution for the pipelined CPU. It holds the N/Z/V flag flops and
//   evaluates the 3-bit condition of the branch in EX. It also computes the
//   PC-relative target. After a taken branch it runs 0..3 architectural delay
//   slots, then pulses redirect/flush for one cycle to reload the PC and
//   squash IF/ID. Saturating branch statistics are kept for debug readout.
//
// Parameters
//   ADDR_W       PC / target width
//   OFF_W        signed word-offset width (must be smaller than ADDR_W)
//   DELAY_SLOTS  delay slots executed after a taken branch, 0..3
//   CNT_W        statistics counter width
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   freezes all state; masks redirect/flush
//   flag_we, n_in/z_in/v_in flag update from the ALU
//   br_valid, br_cond       branch in EX and its condition code
//   br_offset, pc_ex        signed offset and PC+1 of the branch
//   n_ff/z_ff/v_ff          registered flags
//   redirect, redirect_pc   one-cycle PC reload request and its target
//   flush                   squash IF/ID, coincident with redirect
//   err_nested              sticky: branch seen inside a delay slot
//   br_cnt, taken_cnt       saturating evaluated / taken counts
//
// Configuration
//   FLAG_BYPASS_EN: when defined, a branch in the same cycle as flag_we
//   evaluates its condition on n_in/z_in/v_in instead of the flag flops.
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int ADDR_W      = 16,
    parameter int OFF_W       = 9,
    parameter int DELAY_SLOTS = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flag_we,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              v_in,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic [ADDR_W-1:0] pc_ex,
    output logic              n_ff,
    output logic              z_ff,
    output logic              v_ff,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              err_nested,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLOT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    localparam logic [1:0] LP_SLOTS = 2'(DELAY_SLOTS);

    state_t              r_state;
    logic [1:0]          r_slot_cnt;
    logic                r_n, r_z, r_v;
    logic [ADDR_W-1:0]   r_target;
    logic                r_redirect;
    logic                r_err;
    logic [CNT_W-1:0]    r_br_cnt;
    logic [CNT_W-1:0]    r_taken_cnt;

    logic                w_n, w_z, w_v;
    logic                w_taken;
    logic [ADDR_W-1:0]   w_off_ext;
    logic [ADDR_W-1:0]   w_target;

    function automatic logic cond_eval(input logic [2:0] c, input logic n,
                                       input logic z, input logic v);
        logic r;
        case (c)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | ~n;
            3'b101:  r = n | z;
            3'b110:  r = v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

`ifdef FLAG_BYPASS_EN
    // Forward the flags of the instruction directly ahead of the branch.
    logic w_fwd;
    assign w_fwd = flag_we & br_valid;
    assign w_n   = w_fwd ? n_in : r_n;
    assign w_z   = w_fwd ? z_in : r_z;
    assign w_v   = w_fwd ? v_in : r_v;
`else
    assign w_n = r_n;
    assign w_z = r_z;
    assign w_v = r_v;
`endif

    assign w_taken   = cond_eval(br_cond, w_n, w_z, w_v);
    // Sign-extend the word offset; the add wraps modulo 2^ADDR_W.
    assign w_off_ext = {{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign w_target  = pc_ex + w_off_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_v <= 1'b0;
        end else if (!stall && flag_we) begin
            r_n <= n_in;
            r_z <= z_in;
            r_v <= v_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_slot_cnt  <= 2'd0;
            r_target    <= '0;
            r_redirect  <= 1'b0;
            r_err       <= 1'b0;
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (br_valid) begin
                        r_br_cnt <= sat_inc(r_br_cnt);
                        if (w_taken) begin
                            r_taken_cnt <= sat_inc(r_taken_cnt);
                            r_target    <= w_target;
                            if (DELAY_SLOTS == 0) begin
                                r_state    <= S_REDIR;
                                r_redirect <= 1'b1;
                            end else begin
                                r_slot_cnt <= LP_SLOTS;
                                r_state    <= S_SLOT;
                            end
                        end
                    end
                end
                S_SLOT: begin
                    // A branch inside a delay slot is illegal: flag it, never count it.
                    if (br_valid) begin
                        r_err <= 1'b1;
                    end
                    r_slot_cnt <= r_slot_cnt - 2'd1;
                    if (r_slot_cnt == 2'd1) begin
                        r_state    <= S_REDIR;
                        r_redirect <= 1'b1;
                    end
                end
                S_REDIR: begin
                    // br_valid here is a wrong-path instruction and is dropped.
                    r_state    <= S_IDLE;
                    r_redirect <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    // A stalled REDIR cycle holds r_redirect, so the pulse reappears on the
    // first non-stalled cycle and lasts exactly one such cycle.
    assign redirect    = r_redirect & ~stall;
    assign flush       = r_redirect & ~stall;
    assign redirect_pc = r_target;
    assign n_ff        = r_n;
    assign z_ff        = r_z;
    assign v_ff        = r_v;
    assign err_nested  = r_err;
    assign br_cnt      = r_br_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule
